// File: rtl/corescore_rr_pick.sv
// Round-robin selector: grants the first requester after the last owner.
// Ports: i_req requests, i_last last owner; o_gnt one-hot, o_idx index, o_any.
module corescore_rr_pick #(
  parameter int N_SRC = 2,
  parameter int IW    = 1
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_SRC-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  // Scan (last+1 .. last+N_SRC) mod N_SRC; the owner itself comes last.
  always_comb begin
    int c;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    c     = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      c = (int'(i_last) + i) % N_SRC;
      if (!o_any && i_req[c]) begin
        o_any    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/corescore_uart_arbiter.sv
// Packet-atomic round-robin arbiter of N_SRC byte streams onto one UART port.
// Ports: i_clk/i_rst, i_tdata/i_tlast/i_tvalid/o_tready per source, i_uart_ena,
//        o_uart_dat/o_uart_val to UART, o_grant owner one-hot, o_abort watchdog pulse.
module corescore_uart_arbiter #(
  parameter int N_SRC        = 2,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [8*N_SRC-1:0] i_tdata,
  input  logic [N_SRC-1:0]   i_tlast,
  input  logic [N_SRC-1:0]   i_tvalid,
  output logic [N_SRC-1:0]   o_tready,
  input  logic               i_uart_ena,
  output logic [7:0]         o_uart_dat,
  output logic               o_uart_val,
  output logic [N_SRC-1:0]   o_grant,
  output logic               o_abort
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_grant;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_last;
  logic [TO_W-1:0]  r_wd;
  logic [7:0]       r_dat;
  logic             r_val;
  logic             r_abort;

  state_t           w_state_nxt;
  logic [N_SRC-1:0] w_grant_nxt;
  logic [IW-1:0]    w_owner_nxt;
  logic [IW-1:0]    w_last_nxt;
  logic [TO_W-1:0]  w_wd_nxt;
  logic [7:0]       w_dat_nxt;
  logic             w_val_nxt;
  logic             w_abort_nxt;

  logic [N_SRC-1:0] w_pick_gnt;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;

  logic [7:0]       w_sel_dat;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_xfer;

  corescore_rr_pick #(
    .N_SRC (N_SRC),
    .IW    (IW)
  ) u_pick (
    .i_req  (i_tvalid),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_sel_dat   = i_tdata[8*r_owner +: 8];
  assign w_sel_valid = i_tvalid[r_owner];
  assign w_sel_last  = i_tlast[r_owner];
  assign w_xfer      = (r_state == S_SEND) && w_sel_valid && i_uart_ena;

  assign o_tready = (r_state == S_SEND)
                  ? (r_grant & {N_SRC{i_uart_ena}})
                  : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_wd_nxt    = r_wd;
    w_dat_nxt   = r_dat;
    w_val_nxt   = 1'b0;
    w_abort_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = S_SEND;
          w_grant_nxt = w_pick_gnt;
          w_owner_nxt = w_pick_idx;
          w_wd_nxt    = '0;
        end
      end
      S_SEND: begin
        // A transfer beats a simultaneous watchdog expiry.
        if (w_xfer) begin
          w_dat_nxt = w_sel_dat;
          w_val_nxt = 1'b1;
          w_wd_nxt  = '0;
          if (w_sel_last) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_last_nxt  = r_owner;
          end
        end else if (!w_sel_valid) begin
          // Only a silent source ages; UART backpressure freezes it.
          if (r_wd == TO_W'(IDLE_TIMEOUT - 1)) begin
            w_abort_nxt = 1'b1;
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_last_nxt  = r_owner;
            w_wd_nxt    = '0;
          end else begin
            w_wd_nxt = r_wd + TO_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= IW'(N_SRC - 1);
      r_wd    <= '0;
      r_dat   <= 8'h00;
      r_val   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_wd    <= w_wd_nxt;
      r_dat   <= w_dat_nxt;
      r_val   <= w_val_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_uart_dat = r_dat;
  assign o_uart_val = r_val;
  assign o_abort    = r_abort;

endmodule

// File: tb/tb_corescore_uart_arbiter.sv
// Directed bench for corescore_uart_arbiter (N_SRC=2, IDLE_TIMEOUT=8).
// Sources are byte queues; UART output bytes are logged on negedge.
module tb_corescore_uart_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tdata;
  logic [1:0]  tlast;
  logic [1:0]  tvalid;
  logic [1:0]  tready;
  logic        ena;
  logic [7:0]  udat;
  logic        uval;
  logic [1:0]  grant;
  logic        abort;

  int errs   = 0;
  int checks = 0;
  int n_abort = 0;

  logic [8:0] sq0[$];
  logic [8:0] sq1[$];
  bit         gate0;
  bit         gate1;
  logic [7:0] log_q[$];

  always #5 clk = ~clk;

  corescore_uart_arbiter #(
    .N_SRC        (2),
    .IDLE_TIMEOUT (8),
    .TO_W         (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tdata    (tdata),
    .i_tlast    (tlast),
    .i_tvalid   (tvalid),
    .o_tready   (tready),
    .i_uart_ena (ena),
    .o_uart_dat (udat),
    .o_uart_val (uval),
    .o_grant    (grant),
    .o_abort    (abort)
  );

  always @(negedge clk) begin
    if (uval === 1'b1) log_q.push_back(udat);
    if (abort === 1'b1) n_abort++;
  end

  task automatic drive_src();
    logic [8:0] h0;
    logic [8:0] h1;
    h0 = (sq0.size() > 0) ? sq0[0] : 9'h000;
    h1 = (sq1.size() > 0) ? sq1[0] : 9'h000;
    tvalid[0]   = gate0 && (sq0.size() > 0);
    tvalid[1]   = gate1 && (sq1.size() > 0);
    tdata[7:0]  = h0[7:0];
    tdata[15:8] = h1[7:0];
    tlast[0]    = h0[8];
    tlast[1]    = h1[8];
  endtask

  // Sources advance on a handshake, like an AXI-stream master.
  task automatic tick();
    logic x0;
    logic x1;
    logic [8:0] d;
    #1;
    x0 = tvalid[0] & tready[0];
    x1 = tvalid[1] & tready[1];
    @(posedge clk);
    #1;
    if (x0 && sq0.size() > 0) d = sq0.pop_front();
    if (x1 && sq1.size() > 0) d = sq1.pop_front();
    drive_src();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    ena   = 1'b1;
    gate0 = 1'b1;
    gate1 = 1'b1;
    sq0.delete();
    sq1.delete();
    drive_src();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    n_abort = 0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ena   = 1'b0;
    gate0 = 1'b1;
    gate1 = 1'b1;
    sq0.delete();
    sq1.delete();
    drive_src();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 2'b00) begin errs++; $display("FAIL rst_grant got %b want 00", grant); end
    checks++;
    if (uval !== 1'b0) begin errs++; $display("FAIL rst_val got %b want 0", uval); end
    checks++;
    if (udat !== 8'h00) begin errs++; $display("FAIL rst_dat got %h want 00", udat); end
    checks++;
    if (abort !== 1'b0) begin errs++; $display("FAIL rst_abort got %b want 0", abort); end
    checks++;
    if (tready !== 2'b00) begin errs++; $display("FAIL rst_tready got %b want 00", tready); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    sq0.push_back({1'b0, 8'h41});
    sq0.push_back({1'b1, 8'h42});
    drive_src();
    tick();
    checks++;
    if (grant !== 2'b01) begin errs++; $display("FAIL b_grant got %b want 01", grant); end
    checks++;
    if (uval !== 1'b0) begin errs++; $display("FAIL b_val0 got %b want 0", uval); end
    checks++;
    if (tready !== 2'b01) begin errs++; $display("FAIL b_tready got %b want 01", tready); end
    tick();
    checks++;
    if (uval !== 1'b1 || udat !== 8'h41) begin
      errs++; $display("FAIL b_byteA got %b/%h want 1/41", uval, udat);
    end
    tick();
    checks++;
    if (uval !== 1'b1 || udat !== 8'h42) begin
      errs++; $display("FAIL b_byteB got %b/%h want 1/42", uval, udat);
    end
    checks++;
    if (grant !== 2'b00) begin errs++; $display("FAIL b_release got %b want 00", grant); end
    tick();
    checks++;
    if (uval !== 1'b0 || grant !== 2'b00 || tready !== 2'b00) begin
      errs++; $display("FAIL b_idle got %b/%b/%b want 0/00/00", uval, grant, tready);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp [9];
    logic [7:0] got;
    exp = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32, 8'h20, 8'h21, 8'h22};
    do_reset();
    sq0.push_back({1'b0, 8'h10});
    sq0.push_back({1'b0, 8'h11});
    sq0.push_back({1'b1, 8'h12});
    sq0.push_back({1'b0, 8'h20});
    sq0.push_back({1'b0, 8'h21});
    sq0.push_back({1'b1, 8'h22});
    sq1.push_back({1'b0, 8'h30});
    sq1.push_back({1'b0, 8'h31});
    sq1.push_back({1'b1, 8'h32});
    drive_src();
    repeat (15) tick();
    checks++;
    if (log_q.size() != 9) begin
      errs++; $display("FAIL rr_count got %0d want 9", log_q.size());
    end
    for (int i = 0; i < 9; i++) begin
      got = (i < log_q.size()) ? log_q[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin
        errs++; $display("FAIL rr_byte%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic pat [6];
    logic [7:0] exp [4];
    logic [7:0] got;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp = '{8'h50, 8'h51, 8'h52, 8'h53};
    do_reset();
    sq0.push_back({1'b0, 8'h50});
    sq0.push_back({1'b0, 8'h51});
    sq0.push_back({1'b0, 8'h52});
    sq0.push_back({1'b1, 8'h53});
    drive_src();
    tick();
    for (int i = 0; i < 6; i++) begin
      ena = pat[i];
      #1;
      checks++;
      if (tready !== {1'b0, pat[i]}) begin
        errs++; $display("FAIL bp_tready%0d got %b want 0%b", i, tready, pat[i]);
      end
      tick();
    end
    ena = 1'b1;
    repeat (2) tick();
    checks++;
    if (log_q.size() != 4) begin
      errs++; $display("FAIL bp_count got %0d want 4", log_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < log_q.size()) ? log_q[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin
        errs++; $display("FAIL bp_byte%0d got %h want %h", i, got, exp[i]);
      end
    end
    checks++;
    if (n_abort != 0) begin errs++; $display("FAIL bp_abort got %0d want 0", n_abort); end
  endtask

  task automatic test_watchdog();
    do_reset();
    gate0 = 1'b0;
    sq0.push_back({1'b1, 8'h70});
    sq1.push_back({1'b0, 8'h60});
    drive_src();
    tick();
    checks++;
    if (grant !== 2'b10) begin errs++; $display("FAIL wd_grant1 got %b want 10", grant); end
    gate0 = 1'b1;
    drive_src();
    tick();
    checks++;
    if (uval !== 1'b1 || udat !== 8'h60) begin
      errs++; $display("FAIL wd_byte got %b/%h want 1/60", uval, udat);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        checks++;
        if (abort !== 1'b0 || grant !== 2'b10 || tready !== 2'b10) begin
          errs++;
          $display("FAIL wd_hold%0d got %b/%b/%b want 0/10/10", i, abort, grant, tready);
        end
      end else begin
        checks++;
        if (abort !== 1'b1 || grant !== 2'b00) begin
          errs++; $display("FAIL wd_abort got %b/%b want 1/00", abort, grant);
        end
      end
    end
    tick();
    checks++;
    if (grant !== 2'b01 || abort !== 1'b0) begin
      errs++; $display("FAIL wd_pass got %b/%b want 01/0", grant, abort);
    end
    tick();
    checks++;
    if (uval !== 1'b1 || udat !== 8'h70) begin
      errs++; $display("FAIL wd_src0 got %b/%h want 1/70", uval, udat);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    gate1 = 1'b0;
    for (int i = 0; i < 5; i++) sq0.push_back({(i == 4), 8'h80 + 8'(i)});
    sq1.push_back({1'b1, 8'h90});
    drive_src();
    repeat (3) tick();
    checks++;
    if (uval !== 1'b1 || udat !== 8'h81) begin
      errs++; $display("FAIL rm_byte2 got %b/%h want 1/81", uval, udat);
    end
    gate1 = 1'b1;
    drive_src();
    rst = 1'b1;
    #1;
    checks++;
    if (uval !== 1'b0 || grant !== 2'b00 || tready !== 2'b00) begin
      errs++; $display("FAIL rm_async got %b/%b/%b want 0/00/00", uval, grant, tready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sq0.delete();
    sq0.push_back({1'b1, 8'h85});
    drive_src();
    tick();
    checks++;
    if (grant !== 2'b01) begin errs++; $display("FAIL rm_first got %b want 01", grant); end
    tick();
    checks++;
    if (uval !== 1'b1 || udat !== 8'h85) begin
      errs++; $display("FAIL rm_byte got %b/%h want 1/85", uval, udat);
    end
    tick();
    checks++;
    if (grant !== 2'b10) begin errs++; $display("FAIL rm_next got %b want 10", grant); end
  endtask

  task automatic test_back_to_back();
    logic ev;
    do_reset();
    for (int i = 0; i < 8; i++) sq0.push_back({1'b1, 8'hA0 + 8'(i)});
    drive_src();
    for (int t = 1; t <= 12; t++) begin
      tick();
      ev = (t % 2 == 0);
      checks++;
      if (uval !== ev) begin
        errs++; $display("FAIL b2b_val%0d got %b want %b", t, uval, ev);
      end
      if (ev) begin
        checks++;
        if (udat !== 8'hA0 + 8'(t / 2 - 1)) begin
          errs++; $display("FAIL b2b_dat%0d got %h want %h", t, udat, 8'hA0 + 8'(t / 2 - 1));
        end
      end
      checks++;
      if (grant[1] !== 1'b0) begin
        errs++; $display("FAIL b2b_src1_%0d got %b want 0", t, grant[1]);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b0;
    tdata  = '0;
    tlast  = '0;
    tvalid = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
